hazard_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core; companion to the EX-stage forwarding unit.
//  - Generates per-stage enable/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  - Handles three cases: load-use hazards forwarding cannot cover, taken-branch redirects resolved in EX,
//    and multi-cycle data-memory accesses.
//  - Watchdog halts the pipeline on a hung memory access.

---
 rtl/hazard_controller.sv | 140 ++++++++++++++
 tb/tb_hazard_controller.sv | 108 ++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: per-stage enable/flush sequencing for the 5-stage core (load-use, branch redirect, memory wait, watchdog halt)
//
// Ports:
//   clk, rst                  pipeline clock (rising edge), asynchronous active-high reset
//   id_rs1, id_rs2            source registers of the instruction in decode
//   id_use_rs1, id_use_rs2    decoded instruction actually reads rs1 / rs2
//   ex_rd, ex_memread         destination and load flag of the instruction in EX
//   ex_br_taken               taken branch/jump resolved in EX this cycle
//   mem_req, mem_ready        data-memory access in MEM and its completion
//   pc_en, ifid_en, idex_en, exmem_en   stage load enables
//   ifid_flush, idex_flush, memwb_flush stage bubble strobes
//   halted                    sticky watchdog halt (cleared only by rst)
//   perf_*_cnt                saturating event counters, present only with HAZARD_PERF_CNT_EN
//
// MEM_TIMEOUT: MEM_WAIT cycles tolerated before HALT (0 disables the watchdog).
// Optional feature macro: HAZARD_PERF_CNT_EN (adds CNT_W and the perf counter outputs).
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_memstall_cnt,
`endif
  output logic             halted
);
  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  state_t r_state, w_next;
  logic [WW-1:0] r_wcnt, w_wcnt_next;
  logic w_live, w_stall, w_branch, w_loaduse;
  assign w_live = (r_state != HALT);
  // Priority: memory stall > branch flush > load-use; each condition is masked by the ones above it
  assign w_stall = w_live && mem_req && !mem_ready;
  assign w_branch = w_live && !w_stall && ex_br_taken;
  assign w_loaduse = w_live && !w_stall && !ex_br_taken && ex_memread && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
  assign halted = (r_state == HALT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_next;
    end
  end
  always_comb begin
    w_next = r_state;
    w_wcnt_next = r_wcnt;
    case (r_state)
      RUN: begin
        if (w_stall) begin
          w_next = MEM_WAIT;
          w_wcnt_next = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (!w_stall) begin
          w_next = RUN;
          w_wcnt_next = '0;
        end else if ((MEM_TIMEOUT != 0) && (r_wcnt == WW'(MEM_TIMEOUT))) begin
          w_next = HALT;
        end else begin
          w_wcnt_next = (&r_wcnt) ? r_wcnt : r_wcnt + 1'b1;
        end
      end
      default: begin
        w_next = HALT;
      end
    endcase
  end
  always_comb begin
    pc_en = 1'b1;
    ifid_en = 1'b1;
    ifid_flush = 1'b0;
    idex_en = 1'b1;
    idex_flush = 1'b0;
    exmem_en = 1'b1;
    memwb_flush = 1'b0;
    if (!w_live) begin
      pc_en = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exmem_en = 1'b0;
    end else if (w_stall) begin
      // Freeze everything up to EX/MEM; bubble MEM/WB so the waiting access is not written back twice
      pc_en = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exmem_en = 1'b0;
      memwb_flush = 1'b1;
    end else if (w_branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_loaduse) begin
      pc_en = 1'b0;
      ifid_en = 1'b0;
      idex_flush = 1'b1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_lu_cnt, r_fl_cnt, r_ms_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
      r_ms_cnt <= '0;
    end else begin
      if (w_loaduse && !(&r_lu_cnt)) r_lu_cnt <= r_lu_cnt + 1'b1;
      if (w_branch && !(&r_fl_cnt)) r_fl_cnt <= r_fl_cnt + 1'b1;
      if (w_stall && !(&r_ms_cnt)) r_ms_cnt <= r_ms_cnt + 1'b1;
    end
  end
  assign perf_loaduse_cnt = r_lu_cnt;
  assign perf_flush_cnt = r_fl_cnt;
  assign perf_memstall_cnt = r_ms_cnt;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scoreboard bench for hazard_controller
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, mem_req, mem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_loaduse_cnt, perf_flush_cnt, perf_memstall_cnt;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  string tag_q[$];
  // Strobe vector: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted}
  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] ST  = 8'b0000_0010;
  localparam logic [7:0] HLT = 8'b0000_0001;
  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
`ifdef HAZARD_PERF_CNT_EN
    .perf_loaduse_cnt(perf_loaduse_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_memstall_cnt(perf_memstall_cnt),
`endif
    .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] e);
    logic [7:0] obs, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic mq, input logic rdy, input logic [7:0] e);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_memread = mr; ex_br_taken = br; mem_req = mq; mem_ready = rdy;
    chk(tag, e);
  endtask
  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_memread = 0; ex_br_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    chk("reset_strobes", DEF);
    rst = 1'b0;
    step("idle",          5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, DEF);
    step("loaduse_rs2",   5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, LU);
    step("after_loaduse", 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, 0, 0, DEF);
    step("loaduse_rd0",   5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, DEF);
    step("loaduse_nouse", 5'd1, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0, DEF);
    step("loaduse_rs1",   5'd9, 5'd3, 1, 0, 5'd9, 1, 0, 0, 0, LU);
    step("rs1_match_nouse", 5'd9, 5'd3, 0, 1, 5'd9, 1, 0, 0, 0, DEF);
    step("branch_wins",   5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, BR);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (perf_loaduse_cnt === 16'd2) else begin
      failures++;
      $error("FAIL perf_loaduse observed=%0d expected=2", perf_loaduse_cnt);
    end
    checks++;
    assert (perf_flush_cnt === 16'd1) else begin
      failures++;
      $error("FAIL perf_flush observed=%0d expected=1", perf_flush_cnt);
    end
`endif
    for (int i = 0; i < 3; i++)
      step("memstall_br", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, ST);
    step("mem_done_br",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, BR);
    step("post_stall",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, DEF);
    step("single_cycle_mem", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, DEF);
    step("stall_lu_hidden", 5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 1, 0, ST);
    step("req_drop_lu",   5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 0, 0, LU);
    step("back_in_run",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, DEF);
    for (int i = 0; i < 5; i++)
      step("timeout_wait", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, ST);
    step("halt",          5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, HLT);
    step("halt_sticky",   5'd2, 5'd0, 1, 0, 5'd2, 1, 1, 1, 1, HLT);
    step("halt_idle",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, HLT);
    rst = 1'b1;
    chk("reset_from_halt", DEF);
    rst = 1'b0;
    step("run_after_reset", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, DEF);
    step("loaduse_after_reset", 5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, LU);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
